// File: rtl/counter100_ctrl.sv
// Run/pause/clear sequencer for the 3-digit BCD counter: debounced buttons, CE prescaler, clear sequence.
// Build option: define COUNTER100_CTRL_AUTOSTOP_EN to stop RUN at terminal count (999 up / 000 down).
module counter100_ctrl #(
    parameter int unsigned TICK_DIV  = 5000000,
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_RUN,
    input  logic       BTN_CLR,
    input  logic       SW_DIR,
    input  logic [3:0] CNT1,
    input  logic [3:0] CNT2,
    input  logic [3:0] CNT3,
    output logic       CE_OUT,
    output logic       CNT_RESET,
    output logic       REVERSE,
    output logic       RUNNING,
    output logic [1:0] STATE,
    output logic       TC
);

    // state | meaning
    // IDLE  | stopped, direction follows switch
    // RUN   | prescaler running, CE pulses issued
    // PAUSE | stopped mid-count, direction follows switch
    // CLEAR | two-cycle counter load (RESET held, CE in 2nd cycle)
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_CLEAR = 2'b11
    } state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

    state_t          state_q, state_d;
    logic [2:0]      sync1_q, sync1_d;
    logic [2:0]      sync2_q, sync2_d;
    logic [DW-1:0]   db_cnt_q [2];
    logic [DW-1:0]   db_cnt_d [2];
    logic [1:0]      db_lvl_q, db_lvl_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            clr_step_q, clr_step_d;
    logic            ce_out_q, ce_out_d;
    logic            cnt_reset_q, cnt_reset_d;
    logic            reverse_q, reverse_d;
    logic            running_q, running_d;
    logic            tc_q, tc_d;
    logic            press_run, press_clr;
    logic            at_term;

`ifdef COUNTER100_CTRL_AUTOSTOP_EN
    // Digits are only trusted when CE is low, i.e. at least one cycle after the counter moved.
    always_comb begin
        at_term = 1'b0;
        if (!ce_out_q) begin
            if (reverse_q) at_term = ({CNT3, CNT2, CNT1} == 12'h000);
            else           at_term = ({CNT3, CNT2, CNT1} == 12'h999);
        end
    end
`else
    wire unused_digits = ^{CNT3, CNT2, CNT1};
    assign at_term = 1'b0;
`endif

    always_comb begin
        sync1_d = {SW_DIR, BTN_CLR, BTN_RUN};
        sync2_d = sync1_q;

        // Bit 0 = run button, bit 1 = clear button.
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            db_lvl_d[i] = db_lvl_q[i];
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) db_lvl_d[i] = sync2_q[i];
                else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
        press_run = db_lvl_d[0] & ~db_lvl_q[0];
        press_clr = db_lvl_d[1] & ~db_lvl_q[1];

        state_d    = state_q;
        clr_step_d = 1'b0;
        tc_d       = 1'b0;
        unique case (state_q)
            S_IDLE, S_PAUSE: begin
                if (press_clr)      state_d = S_CLEAR;
                else if (press_run) state_d = S_RUN;
            end
            S_RUN: begin
                if (press_clr) begin
                    state_d = S_CLEAR;
                end else if (at_term) begin
                    state_d = S_IDLE;
                    tc_d    = 1'b1;
                end else if (press_run) begin
                    state_d = S_PAUSE;
                end
            end
            S_CLEAR: begin
                clr_step_d = ~clr_step_q;
                if (clr_step_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        presc_d = '0;
        if (state_q == S_RUN && state_d == S_RUN)
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;

        // CE is suppressed on the edge leaving RUN so it never overlaps a CNT_RESET change.
        ce_out_d = ((state_q == S_RUN) && (state_d == S_RUN) && (presc_q == PRESC_LAST))
                 | ((state_q == S_CLEAR) && !clr_step_q);
        cnt_reset_d = (state_d == S_CLEAR);
        running_d   = (state_d == S_RUN);
        reverse_d   = reverse_q;
        if (state_q == S_IDLE || state_q == S_PAUSE) reverse_d = sync2_q[2];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            db_lvl_q    <= '0;
            presc_q     <= '0;
            clr_step_q  <= 1'b0;
            ce_out_q    <= 1'b0;
            cnt_reset_q <= 1'b0;
            reverse_q   <= 1'b0;
            running_q   <= 1'b0;
            tc_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            db_lvl_q    <= db_lvl_d;
            presc_q     <= presc_d;
            clr_step_q  <= clr_step_d;
            ce_out_q    <= ce_out_d;
            cnt_reset_q <= cnt_reset_d;
            reverse_q   <= reverse_d;
            running_q   <= running_d;
            tc_q        <= tc_d;
        end
    end

    assign CE_OUT    = ce_out_q;
    assign CNT_RESET = cnt_reset_q;
    assign REVERSE   = reverse_q;
    assign RUNNING   = running_q;
    assign STATE     = state_q;
    assign TC        = tc_q;

endmodule

// File: tb/tb_counter100_ctrl.sv
// Directed bench for counter100_ctrl with a behavioural 3-digit BCD counter on the CE/RESET outputs.
module tb_counter100_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BTN_RUN = 1'b0;
    logic       BTN_CLR = 1'b0;
    logic       SW_DIR = 1'b0;
    logic [3:0] CNT1, CNT2, CNT3;
    logic       CE_OUT, CNT_RESET, REVERSE, RUNNING, TC;
    logic [1:0] STATE;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ce_count = 0;
    int tc_count = 0;
    int m_val = 0;
    int preset_val = 0;
    logic preset_en = 1'b0;
    int ce_snap;

    counter100_ctrl #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
        .CLK(CLK), .RESET(RESET), .BTN_RUN(BTN_RUN), .BTN_CLR(BTN_CLR), .SW_DIR(SW_DIR),
        .CNT1(CNT1), .CNT2(CNT2), .CNT3(CNT3),
        .CE_OUT(CE_OUT), .CNT_RESET(CNT_RESET), .REVERSE(REVERSE), .RUNNING(RUNNING),
        .STATE(STATE), .TC(TC)
    );

    always #5 CLK = ~CLK;

    // Reference counter: RESET input honoured only on a CE edge.
    always @(posedge CLK) begin
        if (preset_en) m_val <= preset_val;
        else if (CE_OUT) begin
            if (CNT_RESET)    m_val <= REVERSE ? 999 : 0;
            else if (REVERSE) m_val <= (m_val == 0) ? 999 : m_val - 1;
            else              m_val <= (m_val == 999) ? 0 : m_val + 1;
        end
        if (CE_OUT) ce_count <= ce_count + 1;
        if (TC)     tc_count <= tc_count + 1;
    end

    assign CNT1 = 4'(m_val % 10);
    assign CNT2 = 4'((m_val / 10) % 10);
    assign CNT3 = 4'(m_val / 100);

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic preset(input int v);
        preset_val = v;
        preset_en  = 1'b1;
        tick(1);
        preset_en  = 1'b0;
    endtask

    initial begin
        // Reset and quiet idle
        tick(3);
        check("rst_state", STATE, 2'b00);
        check("rst_ce", CE_OUT, 1'b0);
        check("rst_cnt_reset", CNT_RESET, 1'b0);
        check("rst_running", RUNNING, 1'b0);
        RESET = 1'b0;
        preset(0);
        tick(50);
        check("idle_state", STATE, 2'b00);
        check("idle_no_ce", ce_count, 0);
        check("idle_reverse", REVERSE, 1'b0);
        check("idle_cnt_reset", CNT_RESET, 1'b0);
        check("idle_tc", TC, 1'b0);

        // Held run press: 2 sync + 3 debounce cycles
        BTN_RUN = 1'b1;
        tick(4);
        check("run_not_yet", STATE, 2'b00);
        tick(1);
        check("run_state", STATE, 2'b01);
        check("run_running", RUNNING, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            check($sformatf("run_ce_c%0d", i), CE_OUT, (i % 4 == 0) ? 1'b1 : 1'b0);
        end
        tick(3);
        BTN_RUN = 1'b0;
        tick(8);
        check("held_single_press", STATE, 2'b01);

        // Second press pauses and CE stops
        BTN_RUN = 1'b1;
        tick(5);
        check("pause_state", STATE, 2'b10);
        check("pause_running", RUNNING, 1'b0);
        ce_snap = ce_count;
        tick(10);
        check("pause_no_ce", ce_count, ce_snap);
        BTN_RUN = 1'b0;
        tick(8);

        // Resume: prescaler restarts from zero
        BTN_RUN = 1'b1;
        tick(5);
        check("resume_state", STATE, 2'b01);
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check($sformatf("resume_ce_c%0d", i), CE_OUT, (i == 4) ? 1'b1 : 1'b0);
        end
        BTN_RUN = 1'b0;
        tick(8);

        // Bouncing run button, then settled high
        for (int i = 0; i < 10; i++) begin
            BTN_RUN = ~BTN_RUN;
            tick(1);
        end
        check("bounce_no_press", STATE, 2'b01);
        BTN_RUN = 1'b1;
        tick(4);
        check("bounce_settling", STATE, 2'b01);
        tick(1);
        check("bounce_press", STATE, 2'b10);
        BTN_RUN = 1'b0;
        tick(8);

        // Direction switch in PAUSE, then clear loads 999
        preset(123);
        SW_DIR = 1'b1;
        tick(2);
        check("rev_latency", REVERSE, 1'b0);
        tick(1);
        check("rev_pause", REVERSE, 1'b1);
        BTN_CLR = 1'b1;
        tick(4);
        check("clr_not_yet", STATE, 2'b10);
        tick(1);
        check("clr1_state", STATE, 2'b11);
        check("clr1_cnt_reset", CNT_RESET, 1'b1);
        check("clr1_ce", CE_OUT, 1'b0);
        tick(1);
        check("clr2_state", STATE, 2'b11);
        check("clr2_cnt_reset", CNT_RESET, 1'b1);
        check("clr2_ce", CE_OUT, 1'b1);
        tick(1);
        check("clr_done_state", STATE, 2'b00);
        check("clr_done_cnt_reset", CNT_RESET, 1'b0);
        check("clr_done_ce", CE_OUT, 1'b0);
        check("clr_digits_999", {CNT3, CNT2, CNT1}, 12'h999);
        BTN_CLR = 1'b0;
        tick(8);

        // Run down, flip switch while running, then simultaneous run+clr
        BTN_RUN = 1'b1;
        tick(5);
        check("run_down_state", STATE, 2'b01);
        BTN_RUN = 1'b0;
        tick(8);
        SW_DIR = 1'b0;
        tick(5);
        check("rev_frozen_run", REVERSE, 1'b1);
        check("counted_down", (m_val < 999) ? 1'b1 : 1'b0, 1'b1);
        BTN_RUN = 1'b1;
        BTN_CLR = 1'b1;
        tick(5);
        check("both_press_clear", STATE, 2'b11);
        check("rev_frozen_clear", REVERSE, 1'b1);
        tick(2);
        check("both_idle", STATE, 2'b00);
        check("both_digits_999", {CNT3, CNT2, CNT1}, 12'h999);
        tick(1);
        check("rev_follows_idle", REVERSE, 1'b0);
        BTN_RUN = 1'b0;
        BTN_CLR = 1'b0;
        tick(8);

        // Terminal count behaviour from 998 counting up
        preset(998);
        BTN_RUN = 1'b1;
        tick(5);
        check("term_run", STATE, 2'b01);
        BTN_RUN = 1'b0;
        tick(3);
        check("term_ce_low", CE_OUT, 1'b0);
        tick(1);
        check("term_ce", CE_OUT, 1'b1);
        tick(1);
        check("term_digits_999", {CNT3, CNT2, CNT1}, 12'h999);
`ifdef COUNTER100_CTRL_AUTOSTOP_EN
        check("term_still_run", STATE, 2'b01);
        tick(1);
        check("term_tc", TC, 1'b1);
        check("term_idle", STATE, 2'b00);
        tick(1);
        check("term_tc_once", TC, 1'b0);
        ce_snap = ce_count;
        tick(12);
        check("term_no_ce", ce_count, ce_snap);
        check("term_tc_count", tc_count, 1);
`else
        tick(3);
        check("wrap_ce", CE_OUT, 1'b1);
        tick(1);
        check("wrap_digits_000", {CNT3, CNT2, CNT1}, 12'h000);
        check("wrap_state", STATE, 2'b01);
        check("wrap_tc_never", tc_count, 0);
`endif

        // Asynchronous reset in the middle of CLEAR
        BTN_CLR = 1'b1;
        tick(5);
        check("mid_clr_state", STATE, 2'b11);
        RESET = 1'b1;
        #1;
        check("async_rst_state", STATE, 2'b00);
        check("async_rst_cnt_reset", CNT_RESET, 1'b0);
        check("async_rst_running", RUNNING, 1'b0);
        BTN_CLR = 1'b0;
        tick(2);
        RESET = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
